// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the memory-mapped UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_DIVISOR = 4'h8;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_e;

    // A programmed divisor of 0 is treated as 1 clock per bit.
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data; pushes on full and pops
// on empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count are reset,
    // and an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and combinational
// register reads. Define UART_TX_PARITY_EN to append an even parity bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    off;
    logic          wr_tx, wr_st, wr_div;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   divisor;
    logic          ovf;
    tx_state_e     state;
    logic [15:0]   cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif
    logic          unused_wdata;

    assign off          = addr[3:0];
    assign hit          = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_tx        = hit & memwrite & (off == OFF_TXDATA);
    assign wr_st        = hit & memwrite & (off == OFF_STATUS);
    assign wr_div       = hit & memwrite & (off == OFF_DIVISOR);
    assign unused_wdata = ^wdata[31:16];
    assign bit_end      = (cnt == 16'd1);

    // The FSM pops from IDLE, or on the last STOP cycle for a back-to-back frame.
    assign fifo_pop = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wr_tx),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            if (wr_div) divisor <= wdata[15:0];
            if (wr_tx && fifo_full)           ovf <= 1'b1;
            else if (wr_st && wdata[ST_OVF])  ovf <= 1'b0;
        end
    end

    // NOTE: non-blocking assignments throughout, so every branch below reads
    // the pre-edge values of cnt, shreg and state regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state != S_IDLE && !bit_end) cnt <= cnt - 16'd1;
            if (fifo_pop) begin
                state   <= S_START;
                txd     <= 1'b0;
                shreg   <= fifo_dout;
                cnt     <= div_eff(divisor);
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^fifo_dout;
`endif
            end else if (bit_end) begin
                case (state)
                    S_START: begin
                        state <= S_DATA;
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        cnt   <= div_eff(divisor);
                    end
                    S_DATA: begin
                        cnt <= div_eff(divisor);
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            txd   <= par;
`else
                            state <= S_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state <= S_STOP;
                        txd   <= 1'b1;
                        cnt   <= div_eff(divisor);
                    end
`endif
                    S_STOP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: rdata is defaulted before the decode so no path leaves it unassigned.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: begin
                    rdata[ST_BUSY]                   = (state != S_IDLE);
                    rdata[ST_FULL]                   = fifo_full;
                    rdata[ST_EMPTY]                  = fifo_empty;
                    rdata[ST_OVF]                    = ovf;
                    rdata[ST_COUNT_LSB +: 8]         = 8'(fifo_count);
                end
                OFF_DIVISOR: rdata[15:0] = divisor;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a bit-list model of the serial line and register file.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE    = 32'hFFFF_FF00;
    localparam logic [27:0] BASE_HI = 28'hFFFF_FF0;
    localparam int          DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          FB      = 11;
`else
    localparam int          FB      = 10;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] wdata    = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        txd;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .addr     (addr),
        .wdata    (wdata),
        .hit      (hit),
        .rdata    (rdata),
        .txd      (txd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, plus the current frame as a list of line bits.
    logic [7:0]  mq[$];
    logic        m_bits[$];
    logic [15:0] m_div;
    logic        m_ovf;
    logic        m_active;
    logic        m_line;
    int          m_rem;

    function automatic int m_deff();
        return (m_div == 16'd0) ? 1 : int'(m_div);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_bits.delete();
        m_div    = 16'd434;
        m_ovf    = 1'b0;
        m_active = 1'b0;
        m_line   = 1'b1;
        m_rem    = 0;
    endtask

    task automatic m_start();
        logic [7:0] b;
        b = mq.pop_front();
        m_bits.delete();
        for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        m_bits.push_back(^b);
`endif
        m_bits.push_back(1'b1);
        m_line   = 1'b0;
        m_rem    = m_deff();
        m_active = 1'b1;
    endtask

    task automatic m_step();
        logic full_pre, empty_pre;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        if (m_active) begin
            if (m_rem > 1) m_rem--;
            else if (m_bits.size() > 0) begin
                m_line = m_bits.pop_front();
                m_rem  = m_deff();
            end else if (!empty_pre) m_start();
            else begin
                m_active = 1'b0;
                m_line   = 1'b1;
            end
        end else if (!empty_pre) m_start();
        if (memwrite && addr[31:4] == BASE_HI) begin
            case (addr[3:0])
                4'h0: if (full_pre) m_ovf = 1'b1; else mq.push_back(wdata[7:0]);
                4'h4: if (wdata[3]) m_ovf = 1'b0;
                4'h8: m_div = wdata[15:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (a[31:4] != BASE_HI) return 32'h0;
        case (a[3:0])
            4'h4: return {16'h0, 8'(mq.size()), 4'h0, m_ovf, mq.size() == 0,
                          mq.size() == DEPTH, m_active};
            4'h8: return {16'h0, m_div};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else        m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("txd", {31'h0, txd}, {31'h0, m_line});
        check("hit", {31'h0, hit}, {31'h0, addr[31:4] == BASE_HI});
        check("rdata", rdata, m_rdata(addr));
    end

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr     = BASE | {28'h0, off};
        wdata    = d;
        memwrite = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] v);
        addr     = BASE | {28'h0, off};
        memwrite = 1'b0;
        #1;
        v = rdata;
    endtask

    initial begin
        logic [31:0]     v;
        logic [FB-1:0]   p1;
        logic [2*FB-1:0] p2;
        int              r;
`ifdef UART_TX_PARITY_EN
        logic [10:0]     p3;
        p1 = 11'b10010101010;
        p2 = {11'b10001111000, 11'b10101001010};
        p3 = 11'b11000001110;
`else
        p1 = 10'b1010101010;
        p2 = {10'b1001111000, 10'b1101001010};
`endif

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_txd", {31'h0, txd}, 32'h1);
        rd(4'h4, v); check("rst_status", v, 32'h0000_0004);
        rd(4'h8, v); check("rst_div", v, 32'd434);

        // Single byte, 4 clocks per bit.
        @(posedge clk); #1;
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h55);
        check("sb_pre", {31'h0, txd}, 32'h1);
        for (int j = 0; j < FB * 4; j++) begin
            @(posedge clk); #1;
            check("sb_bit", {31'h0, txd}, {31'h0, p1[j / 4]});
        end
        @(posedge clk); #1;
        rd(4'h4, v); check("sb_done", v, 32'h0000_0004);

        // Back-to-back frames, 2 clocks per bit.
        @(posedge clk); #1;
        wr(4'h8, 32'd2);
        wr(4'h0, 32'hA5);
        wr(4'h0, 32'h3C);
        addr = BASE | 32'h4;
        for (int j = 0; j < 2 * FB * 2; j++) begin
            #1;
            check("b2b_bit", {31'h0, txd}, {31'h0, p2[j / 2]});
            check("b2b_busy", {31'h0, rdata[0]}, 32'h1);
            @(posedge clk);
        end
        #1;
        rd(4'h4, v); check("b2b_done", v, 32'h0000_0004);

        // Overflow: ten consecutive pushes, one popped, eight stored, one dropped.
        @(posedge clk); #1;
        wr(4'h8, 32'd1000);
        for (int i = 0; i < 10; i++) wr(4'h0, 32'(i + 1));
        rd(4'h4, v); check("ovf_status", v, 32'h0000_080B);
        @(posedge clk); #1;
        wr(4'h4, 32'h8);
        rd(4'h4, v); check("ovf_clear", v, 32'h0000_0803);

        // Reset in the middle of a start bit.
        @(posedge clk); #1;
        check("pre_rst_txd", {31'h0, txd}, 32'h0);
        reset = 1'b0;
        #1;
        check("mid_rst_txd", {31'h0, txd}, 32'h1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rd(4'h4, v); check("post_rst_status", v, 32'h0000_0004);
        rd(4'h8, v); check("post_rst_div", v, 32'd434);

        // Decode: out-of-window store, then the reserved offset.
        @(posedge clk); #1;
        addr = 32'h0000_1000; wdata = 32'h77; memwrite = 1'b1;
        #1;
        check("dec_hit", {31'h0, hit}, 32'h0);
        check("dec_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        memwrite = 1'b0;
        rd(4'h4, v); check("dec_nopush", v, 32'h0000_0004);
        @(posedge clk); #1;
        rd(4'hC, v);
        check("c_hit", {31'h0, hit}, 32'h1);
        check("c_rdata", v, 32'h0);

`ifdef UART_TX_PARITY_EN
        @(posedge clk); #1;
        wr(4'h8, 32'd1);
        wr(4'h0, 32'h07);
        for (int j = 0; j < 11; j++) begin
            @(posedge clk); #1;
            check("par_bit", {31'h0, txd}, {31'h0, p3[j]});
        end
        repeat (2) @(posedge clk);
        #1;
`endif

        // Randomized traffic, checked by the per-cycle compare process.
        @(posedge clk); #1;
        wr(4'h8, 32'd1);
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                addr = BASE; wdata = $urandom; memwrite = 1'b1;
            end else if (r < 36) begin
                addr = BASE | 32'h8;
                wdata = {16'($urandom), 16'($urandom_range(0, 3))};
                memwrite = 1'b1;
            end else if (r < 42) begin
                addr = BASE | 32'h4; wdata = $urandom; memwrite = 1'b1;
            end else if (r < 46) begin
                addr = $urandom; wdata = $urandom; memwrite = 1'b1;
            end else if (r < 49) begin
                addr = BASE | 32'hC; wdata = $urandom; memwrite = 1'b1;
            end else begin
                addr = {BASE_HI, 4'($urandom)}; memwrite = 1'b0;
            end
            @(posedge clk); #1;
        end
        memwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
